// File: rtl/xor_frame_checker.sv
// xor_frame_checker: checks framed bit-serial (u,v,w) beats against w = u^v and reports one record per frame.
module xor_frame_checker #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             u,
   input  logic             v,
   input  logic             w,
   input  logic             in_last,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_len,
   output logic [CNT_W-1:0] res_mism,
   output logic [CNT_W-1:0] res_first_err,
   output logic             res_parity,
   output logic             res_ovf,
   output logic             res_pass
);
   typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
   state_t state;
   logic [CNT_W-1:0] len, mism, first_err, len_n, mism_n, first_err_n;
   logic seen, parity, ovf, fire, err, at_max, ovf_n, parity_n;
   always_comb begin
      fire        = in_valid && in_ready;
      err         = w ^ u ^ v;
      at_max      = &len;
      len_n       = at_max ? len : len + CNT_W'(1);
      ovf_n       = ovf || at_max;
      mism_n      = (err && !(&mism)) ? mism + CNT_W'(1) : mism;
      first_err_n = (err && !seen) ? len : first_err;
      parity_n    = parity ^ w;
   end
   // Accumulators hold the open frame; the res_* registers hold the record frozen for REPORT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         in_ready      <= 1'b0;
         res_valid     <= 1'b0;
         len           <= '0;
         mism          <= '0;
         first_err     <= '1;
         seen          <= 1'b0;
         parity        <= 1'b0;
         ovf           <= 1'b0;
         res_len       <= '0;
         res_mism      <= '0;
         res_first_err <= '1;
         res_parity    <= 1'b0;
         res_ovf       <= 1'b0;
         res_pass      <= 1'b0;
      end else if (state == REPORT) begin
         if (res_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            len       <= '0;
            mism      <= '0;
            first_err <= '1;
            seen      <= 1'b0;
            parity    <= 1'b0;
            ovf       <= 1'b0;
         end
      end else begin
         in_ready <= 1'b1;
         if (fire && in_last) begin
            state         <= REPORT;
            in_ready      <= 1'b0;
            res_valid     <= 1'b1;
            res_len       <= len_n;
            res_mism      <= mism_n;
            res_first_err <= first_err_n;
            res_parity    <= parity_n;
            res_ovf       <= ovf_n;
            res_pass      <= (mism_n == '0) && !ovf_n;
         end else if (fire) begin
            state     <= ACCUM;
            len       <= len_n;
            mism      <= mism_n;
            first_err <= first_err_n;
            seen      <= seen || err;
            parity    <= parity_n;
            ovf       <= ovf_n;
         end
      end
   end
endmodule
